// File: rtl/inst_fetch_buffer.sv
// rtl/inst_fetch_buffer.sv - instruction fetch responder over a 2-entry direct-mapped word buffer
module inst_fetch_buffer #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  output logic              inst_valid,
  output logic              inst_comp,
  output logic [31:0]       inst,
  output logic              request,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              resp_valid,
  input  logic [63:0]       resp_data
);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [1:0]          valid_q;
  logic [ADDR_W-5:0]   tag_q [2];
  logic [63:0]         data_q [2];

  logic [ADDR_W-1:0]   word_addr, next_addr;
  logic                idx_lo, idx_hi;
  logic [1:0]          half;
  logic [15:0]         lo, hi;
  logic                lo_hit, hi_hit, comp, straddle, fill;
  logic                unused_pc0;

  assign unused_pc0 = pc[0];
  assign word_addr  = {pc[ADDR_W-1:3], 3'b000};
  // Wraps modulo 2^ADDR_W, so the top word straddles into word 0.
  assign next_addr  = word_addr + ADDR_W'(8);
  assign idx_lo     = word_addr[3];
  assign idx_hi     = next_addr[3];
  assign half       = pc[2:1];

  assign lo       = data_q[idx_lo][{half, 4'b0000} +: 16];
  assign hi       = data_q[idx_hi][15:0];
  assign lo_hit   = valid_q[idx_lo] && (tag_q[idx_lo] == word_addr[ADDR_W-1:4]);
  assign hi_hit   = valid_q[idx_hi] && (tag_q[idx_hi] == next_addr[ADDR_W-1:4]);
  assign comp     = (lo[1:0] != 2'b11);
  assign straddle = !comp && (half == 2'd3);

  assign inst_valid = lo_hit && (!straddle || hi_hit);
  assign inst_comp  = comp;
  assign inst       = comp ? {16'h0000, lo} : {hi, lo};
  assign request    = (state_q == WAIT);
  assign req_addr   = req_addr_q;

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    fill       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!lo_hit) begin
          req_addr_d = word_addr;
          state_d    = WAIT;
        end else if (straddle && !hi_hit) begin
          req_addr_d = next_addr;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (resp_valid) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      valid_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      if (fill) begin
        valid_q[req_addr_q[3]] <= 1'b1;
      end
    end
  end

  // Tags and data are qualified by valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    if (rst_n && fill) begin
      tag_q[req_addr_q[3]]  <= req_addr_q[ADDR_W-1:4];
      data_q[req_addr_q[3]] <= resp_data;
    end
  end

endmodule

// File: doc/inst_fetch_buffer.md
Name: inst_fetch_buffer

Overview:
- Instruction-fetch responder for the PC-driven front end. It takes the requested pc and returns the instruction at that address, as inst/inst_valid/inst_comp.
- Holds a 2-entry direct-mapped buffer of 64-bit memory words. It serves 16-bit (compressed) and 32-bit instructions, including 32-bit instructions that straddle a word boundary.
- Misses are fetched from the memory side over a single-outstanding request/response handshake.

Parameters:
- ADDR_W, 64, width of pc and req_addr.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- pc  input  ADDR_W  fetch address from front end; bit 0 ignored (treated as 0).
- inst_valid  output  1  inst/inst_comp valid for current pc.
- inst_comp  output  1  1 = 16-bit instruction.
- inst  output  32  instruction; compressed returned as {16'h0, half}.
- request  output  1  memory read request pending.
- req_addr  output  ADDR_W  8-byte-aligned word address being requested.
- resp_valid  input  1  memory response strobe (one cycle).
- resp_data  input  64  memory word for req_addr, little-endian halfwords.

Behaviour:
- Clock and reset: one clock clk; reset rst_n is synchronous and active-low, sampled on the posedge of clk.

Storage and lookup:
- Entry index = addr[3], tag = addr[ADDR_W-1:4], valid bit per entry.
- Word address W = {pc[ADDR_W-1:3], 3'b0}; halfword offset h = pc[2:1].
- lo = halfword h of word W.
- comp = (lo[1:0] != 2'b11).
- Straddle = !comp && h == 3; the upper halfword is then halfword 0 of word W+8 (the other entry).
- Hit requires W valid and tag-matched. A straddle additionally requires W+8 valid and tag-matched.

Outputs:
- inst_valid = hit. It is combinational from pc and buffer state, so a hit yields an instruction in the same cycle.
- inst_comp = comp. It is don't-care when inst_valid = 0.
- inst = comp ? {16'h0, lo} : {hi, lo}.

FSM:
- IDLE:
  - If W is missing: req_addr <= W, go to WAIT.
  - Else if the straddle word is missing: req_addr <= W+8, go to WAIT.
  - Else stay in IDLE.
- WAIT:
  - request = 1, req_addr held stable.
  - On resp_valid: write resp_data into entry req_addr[3], set tag = req_addr[ADDR_W-1:4], set valid = 1, go to IDLE.
- request = (state == WAIT), registered.
- Miss latency: request rises the cycle after a miss is seen. inst_valid rises the cycle after resp_valid, or re-requests if a second word is still missing.
- Straddle across two missing words takes two sequential fetches, W first.

Boundary conditions:
- pc changes while in WAIT: the fill still goes to the recorded req_addr; lookup is re-evaluated in IDLE.
- resp_valid while in IDLE: ignored.
- A fill overwrites (evicts) whatever entry occupies that index.
- Address wrap: W+8 wraps modulo 2^ADDR_W.

Reset (rst_n = 0 at posedge):
- state = IDLE, both valids = 0, request = 0, req_addr = 0.
- This applies mid-WAIT: the outstanding request is abandoned and a late resp_valid is ignored.
- inst_valid is therefore 0 immediately after reset.

Test Plan:
Memory contents: word 0x0 = 64'h0297_4501_0000_0513; word 0x8 = 64'h0001_0001_0001_0000; word 0x10 = 64'h0000_0000_0000_0001.
1. Reset, pc = 0:
   - Next cycle request = 1, req_addr = 0x0.
   - resp_valid with word 0x0 → next cycle inst_valid = 1, inst = 0x00000513, inst_comp = 0.
2. Following (1), pc = 4 → same cycle inst_valid = 1, inst = 0x00004501, inst_comp = 1, request stays 0.
3. pc = 6 (straddle):
   - inst_valid = 0; next cycle request = 1, req_addr = 0x8.
   - After response: inst = 0x00000297, inst_comp = 0.
4. pc = 0x10:
   - Miss, req_addr = 0x10, fill evicts entry 0; inst = 0x00000001, inst_comp = 1.
   - Then pc = 0 → miss again, req_addr = 0x0.
5. Delayed response: resp_valid held off 5 cycles → request = 1 and req_addr stable throughout, inst_valid = 0; fill completes on the 6th cycle.
6. Reset mid-WAIT:
   - rst_n = 0 for one cycle while request = 1, then resp_valid arrives → request = 0, response ignored.
   - Re-presenting the same pc re-issues the request.
